dlx_mem_arbiter: RTL and testbench

Shares one single-ported unified memory between the DLX instruction-fetch port and the data (MEM-stage) port. It sits between the processor's `instr_*` / `data_*` ports and the external memory. It serialises requests through a registered request/acknowledge FSM that tolerates variable memory latency. It also produces the pipeline stall that holds the core while either port is waiting.

---
 rtl/dlx_mem_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_dlx_mem_arbiter.sv | 514 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dlx_mem_arbiter.sv
// dlx_mem_arbiter
// Shares one single-ported unified memory between the DLX instruction-fetch
// port and the data (MEM-stage) port. Requests are serialised through a
// registered IDLE -> BUSY -> DONE handshake that tolerates any memory latency.
// Data requests normally win. A saturating streak counter bounds how many
// data grants in a row may be made while a fetch is waiting. The combinational
// stall output holds the core while either port is still waiting for its ack.

module dlx_mem_arbiter #(
    parameter int DATA_WIDTH      = 32,
    parameter int INST_ADDR_WIDTH = 20,
    parameter int DATA_ADDR_WIDTH = 32,
    parameter int MEM_ADDR_WIDTH  = 32,
    parameter int MAX_DATA_BURST  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,

    input  logic                       instr_rd_en,
    input  logic [INST_ADDR_WIDTH-1:0] instr_addr,
    output logic [DATA_WIDTH-1:0]      instr_rdata,
    output logic                       instr_ack,

    input  logic                       data_rd_en,
    input  logic                       data_wr_en,
    input  logic [DATA_ADDR_WIDTH-1:0] data_addr,
    input  logic [DATA_WIDTH-1:0]      data_write,
    output logic [DATA_WIDTH-1:0]      data_rdata,
    output logic                       data_ack,

    output logic                       stall,

    output logic                       mem_req,
    output logic                       mem_we,
    output logic [MEM_ADDR_WIDTH-1:0]  mem_addr,
    output logic [DATA_WIDTH-1:0]      mem_wdata,
    input  logic [DATA_WIDTH-1:0]      mem_rdata,
    input  logic                       mem_ack
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] BURST_LIMIT = 4'(MAX_DATA_BURST);
    localparam logic [3:0] STREAK_MAX  = 4'hF;

    state_t                      state_q, state_d;
    logic                        owner_data_q, owner_data_d;
    logic [3:0]                  streak_q, streak_d;

    logic                        mem_req_d;
    logic                        mem_we_d;
    logic [MEM_ADDR_WIDTH-1:0]   mem_addr_d;
    logic [DATA_WIDTH-1:0]       mem_wdata_d;
    logic                        instr_ack_d;
    logic                        data_ack_d;
    logic [DATA_WIDTH-1:0]       instr_rdata_d;
    logic [DATA_WIDTH-1:0]       data_rdata_d;

    logic [MEM_ADDR_WIDTH-1:0]   instr_addr_ext;
    logic [MEM_ADDR_WIDTH-1:0]   data_addr_ext;
    logic                        data_req;
    logic                        grant_instr;

    // Fit both requester addresses to the memory address width.
    // Narrower addresses are zero-extended; wider ones keep their low bits.
    generate
        if (MEM_ADDR_WIDTH > INST_ADDR_WIDTH) begin : g_instr_ext
            assign instr_addr_ext = {{(MEM_ADDR_WIDTH-INST_ADDR_WIDTH){1'b0}}, instr_addr};
        end else begin : g_instr_trunc
            assign instr_addr_ext = instr_addr[MEM_ADDR_WIDTH-1:0];
        end

        if (MEM_ADDR_WIDTH > DATA_ADDR_WIDTH) begin : g_data_ext
            assign data_addr_ext = {{(MEM_ADDR_WIDTH-DATA_ADDR_WIDTH){1'b0}}, data_addr};
        end else begin : g_data_trunc
            assign data_addr_ext = data_addr[MEM_ADDR_WIDTH-1:0];
        end
    endgenerate

    // A store wins over a load on the data port, so any enable is a data request.
    // The fetch only wins when data is idle or has used up its burst allowance.
    assign data_req    = data_rd_en | data_wr_en;
    assign grant_instr = instr_rd_en & (~data_req | (streak_q == BURST_LIMIT));

    // The stall drops in the same cycle as the matching ack, before the requester updates.
    assign stall = (instr_rd_en & ~instr_ack) | (data_req & ~data_ack);

    // Next-state and next-register values. The mem_* bus holds its value
    // unless a grant or completion changes it. The acks default low so each
    // one is a single-cycle pulse.
    always_comb begin
        state_d       = state_q;
        owner_data_d  = owner_data_q;
        streak_d      = streak_q;
        mem_req_d     = mem_req;
        mem_we_d      = mem_we;
        mem_addr_d    = mem_addr;
        mem_wdata_d   = mem_wdata;
        instr_ack_d   = 1'b0;
        data_ack_d    = 1'b0;
        instr_rdata_d = instr_rdata;
        data_rdata_d  = data_rdata;

        unique case (state_q)
            IDLE: begin
                if (instr_rd_en | data_req) begin
                    state_d   = BUSY;
                    mem_req_d = 1'b1;
                    if (grant_instr) begin
                        owner_data_d = 1'b0;
                        mem_we_d     = 1'b0;
                        mem_addr_d   = instr_addr_ext;
                        mem_wdata_d  = '0;
                        streak_d     = '0;
                    end else begin
                        owner_data_d = 1'b1;
                        mem_we_d     = data_wr_en;
                        mem_addr_d   = data_addr_ext;
                        mem_wdata_d  = data_write;
                        if (instr_rd_en) begin
                            streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + 4'd1;
                        end else begin
                            streak_d = '0;
                        end
                    end
                end
            end

            BUSY: begin
                if (mem_ack) begin
                    state_d   = DONE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    if (owner_data_q) begin
                        data_ack_d = 1'b1;
                        if (!mem_we) begin
                            data_rdata_d = mem_rdata;
                        end
                    end else begin
                        instr_ack_d   = 1'b1;
                        instr_rdata_d = mem_rdata;
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers. An asynchronous reset clears everything
    // at once, and an interrupted memory cycle is simply dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            owner_data_q <= 1'b0;
            streak_q     <= '0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            instr_ack    <= 1'b0;
            data_ack     <= 1'b0;
            instr_rdata  <= '0;
            data_rdata   <= '0;
        end else begin
            state_q      <= state_d;
            owner_data_q <= owner_data_d;
            streak_q     <= streak_d;
            mem_req      <= mem_req_d;
            mem_we       <= mem_we_d;
            mem_addr     <= mem_addr_d;
            mem_wdata    <= mem_wdata_d;
            instr_ack    <= instr_ack_d;
            data_ack     <= data_ack_d;
            instr_rdata  <= instr_rdata_d;
            data_rdata   <= data_rdata_d;
        end
    end

endmodule

// File: tb/tb_dlx_mem_arbiter.sv
// tb_dlx_mem_arbiter
// Drives the arbiter with directed scenarios and a randomized run.
// A variable-latency memory device model sits behind the arbiter.
// A transaction-level reference model predicts grants, acks, read data and stall.

`timescale 1ns/1ps

module tb_dlx_mem_arbiter;

    localparam int DW    = 32;
    localparam int IAW   = 20;
    localparam int DAW   = 32;
    localparam int MAW   = 32;
    localparam int BURST = 4;

    logic           clk;
    logic           rst_n;
    logic           instr_rd_en;
    logic [IAW-1:0] instr_addr;
    logic [DW-1:0]  instr_rdata;
    logic           instr_ack;
    logic           data_rd_en;
    logic           data_wr_en;
    logic [DAW-1:0] data_addr;
    logic [DW-1:0]  data_write;
    logic [DW-1:0]  data_rdata;
    logic           data_ack;
    logic           stall;
    logic           mem_req;
    logic           mem_we;
    logic [MAW-1:0] mem_addr;
    logic [DW-1:0]  mem_wdata;
    logic [DW-1:0]  mem_rdata;
    logic           mem_ack;

    int checks;
    int errors;

    logic [DW-1:0] dev_mem [64];
    logic [DW-1:0] ref_mem [64];
    bit            mem_auto;
    bit            mem_lat_rand;
    int            mem_lat_fixed;
    int            mem_cnt;
    int            cur_lat;

    dlx_mem_arbiter #(
        .DATA_WIDTH      (DW),
        .INST_ADDR_WIDTH (IAW),
        .DATA_ADDR_WIDTH (DAW),
        .MEM_ADDR_WIDTH  (MAW),
        .MAX_DATA_BURST  (BURST)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_rd_en (instr_rd_en),
        .instr_addr  (instr_addr),
        .instr_rdata (instr_rdata),
        .instr_ack   (instr_ack),
        .data_rd_en  (data_rd_en),
        .data_wr_en  (data_wr_en),
        .data_addr   (data_addr),
        .data_write  (data_write),
        .data_rdata  (data_rdata),
        .data_ack    (data_ack),
        .stall       (stall),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack)
    );

    // 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case a scenario hangs
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired got=running exp=finished");
        $fatal(1, "[TB] watchdog");
    end

    // Memory device: answers mem_req after L cycles (L=1 means ack in the first
    // request cycle) with a one-cycle mem_ack. Writes return junk on mem_rdata.
    task automatic mem_step();
        if (mem_ack) begin
            mem_ack = 1'b0;
            mem_cnt = 0;
        end else if (!mem_req) begin
            mem_cnt = 0;
        end else if (mem_auto) begin
            mem_cnt++;
            if (mem_cnt == 1) cur_lat = mem_lat_rand ? int'($urandom_range(1, 4)) : mem_lat_fixed;
            if (mem_cnt >= cur_lat) begin
                mem_ack = 1'b1;
                if (mem_we) begin
                    dev_mem[mem_addr[7:2]] = mem_wdata;
                    mem_rdata = $urandom;
                end else begin
                    mem_rdata = dev_mem[mem_addr[7:2]];
                end
            end
        end
    endtask

    // Advance one clock; the memory device reacts just after the edge
    task automatic tick();
        @(posedge clk);
        #1;
        mem_step();
    endtask

    // Reset with all requesters idle; returns just after a rising edge with rst_n high
    task automatic do_reset();
        rst_n = 1'b0;
        instr_rd_en = 1'b0;  instr_addr = '0;
        data_rd_en  = 1'b0;  data_wr_en = 1'b0;
        data_addr   = '0;    data_write = '0;
        mem_ack = 1'b0;  mem_rdata = '0;  mem_cnt = 0;  cur_lat = 1;
        mem_auto = 1'b1;  mem_lat_rand = 1'b0;  mem_lat_fixed = 1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        instr_rd_en = 1'b0;  instr_addr = '0;
        data_rd_en  = 1'b0;  data_wr_en = 1'b0;
        data_addr   = '0;    data_write = '0;
        mem_ack = 1'b0;  mem_rdata = '0;
        #3 rst_n = 1'b0;
        @(posedge clk);
        #2;
        checks++;
        if ({mem_req, mem_we, instr_ack, data_ack} !== 4'b0000)
            $display("[TB] FAIL reset_ctrl got=%b exp=0000", {mem_req, mem_we, instr_ack, data_ack});
        else ;
        if ({mem_req, mem_we, instr_ack, data_ack} !== 4'b0000) errors++;
        checks++;
        if (mem_addr !== '0 || mem_wdata !== '0) begin
            errors++;
            $display("[TB] FAIL reset_mem_bus got=%h/%h exp=0/0", mem_addr, mem_wdata);
        end
        checks++;
        if (instr_rdata !== '0 || data_rdata !== '0) begin
            errors++;
            $display("[TB] FAIL reset_rdata got=%h/%h exp=0/0", instr_rdata, data_rdata);
        end
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_stall got=%b exp=0", stall);
        end
    endtask

    task automatic test_single_fetch();
        do_reset();
        dev_mem[0] = 32'h2001_0005;
        instr_addr = 20'h40000;
        instr_rd_en = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b1) begin errors++; $display("[TB] FAIL fetch_stall_c0 got=%b exp=1", stall); end
        tick(); #1;
        checks++;
        if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h0004_0000}) begin
            errors++;
            $display("[TB] FAIL fetch_mem_c1 got=req%b we%b addr%h exp=req1 we0 addr00040000", mem_req, mem_we, mem_addr);
        end
        checks++;
        if ({stall, instr_ack} !== 2'b10) begin errors++; $display("[TB] FAIL fetch_c1 got=stall%b ack%b exp=stall1 ack0", stall, instr_ack); end
        tick(); #1;
        checks++;
        if ({instr_ack, stall, mem_req} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL fetch_c2 got=ack%b stall%b req%b exp=ack1 stall0 req0", instr_ack, stall, mem_req);
        end
        checks++;
        if (instr_rdata !== 32'h2001_0005) begin errors++; $display("[TB] FAIL fetch_rdata got=%h exp=20010005", instr_rdata); end
        tick();
        instr_rd_en = 1'b0;
        #1;
        checks++;
        if ({instr_ack, mem_req} !== 2'b00) begin errors++; $display("[TB] FAIL fetch_c3 got=ack%b req%b exp=0 0", instr_ack, mem_req); end
    endtask

    task automatic test_simultaneous();
        int   ack_order[$];
        int   dack_cyc;
        int   igrant_cyc;
        logic prev_req;
        bit   first;
        do_reset();
        mem_lat_fixed = 2;
        dev_mem[17] = 32'hA5A5_0044;
        dev_mem[32] = 32'h5A5A_0080;
        dack_cyc = -10;  igrant_cyc = -1;  prev_req = 1'b0;  first = 1'b1;
        instr_addr = 20'h00080;  data_addr = 32'h44;
        instr_rd_en = 1'b1;  data_rd_en = 1'b1;
        for (int c = 1; c <= 40 && ack_order.size() < 2; c++) begin
            tick();
            if (dack_cyc == c - 1) data_rd_en = 1'b0;
            #1;
            if (mem_req && !prev_req) begin
                if (first) begin
                    checks++;
                    if (mem_addr !== 32'h44) begin errors++; $display("[TB] FAIL simul_first_grant got=%h exp=00000044", mem_addr); end
                    first = 1'b0;
                end else if (igrant_cyc < 0) begin
                    igrant_cyc = c;
                end
            end
            prev_req = mem_req;
            if (data_ack) begin ack_order.push_back(1); dack_cyc = c; end
            if (instr_ack) ack_order.push_back(0);
        end
        tick();
        instr_rd_en = 1'b0;
        data_rd_en = 1'b0;
        checks++;
        if (ack_order.size() != 2 || ack_order[0] != 1 || ack_order[1] != 0) begin
            errors++;
            $display("[TB] FAIL simul_ack_order got=%0d acks first=%0d exp=2 acks data then instr", ack_order.size(), (ack_order.size() > 0) ? ack_order[0] : -1);
        end
        checks++;
        if (igrant_cyc != dack_cyc + 2) begin errors++; $display("[TB] FAIL simul_instr_grant got=cycle%0d exp=cycle%0d", igrant_cyc, dack_cyc + 2); end
        checks++;
        if (data_rdata !== 32'hA5A5_0044 || instr_rdata !== 32'h5A5A_0080) begin
            errors++;
            $display("[TB] FAIL simul_rdata got=%h/%h exp=a5a50044/5a5a0080", data_rdata, instr_rdata);
        end
    endtask

    task automatic test_starvation();
        int   grants;
        logic prev_req;
        logic exp_instr;
        logic got_instr;
        do_reset();
        mem_lat_rand = 1'b1;
        grants = 0;  prev_req = 1'b0;
        instr_addr = 20'h00100;  data_addr = 32'h200;
        instr_rd_en = 1'b1;  data_rd_en = 1'b1;
        for (int c = 0; c < 300 && grants < 10; c++) begin
            tick(); #1;
            if (mem_req && !prev_req) begin
                exp_instr = ((grants % (BURST + 1)) == BURST);
                got_instr = (mem_addr == 32'h100);
                checks++;
                if (got_instr !== exp_instr) begin
                    errors++;
                    $display("[TB] FAIL starve_grant%0d got=%s exp=%s", grants, got_instr ? "I" : "D", exp_instr ? "I" : "D");
                end
                grants++;
            end
            prev_req = mem_req;
        end
        checks++;
        if (grants != 10) begin errors++; $display("[TB] FAIL starve_timeout got=%0d grants exp=10", grants); end
        instr_rd_en = 1'b0;
        data_rd_en = 1'b0;
        tick();
    endtask

    task automatic test_store();
        do_reset();
        dev_mem[1] = 32'h1234_5678;
        data_addr = 32'h104;
        data_rd_en = 1'b1;
        tick();
        tick(); #1;
        checks++;
        if ({data_ack, data_rdata} !== {1'b1, 32'h1234_5678}) begin
            errors++;
            $display("[TB] FAIL store_preload got=ack%b %h exp=ack1 12345678", data_ack, data_rdata);
        end
        tick();
        mem_lat_fixed = 3;
        data_rd_en = 1'b1;  data_wr_en = 1'b1;
        data_addr = 32'h100;  data_write = 32'hDEAD_BEEF;
        for (int c = 1; c <= 3; c++) begin
            tick(); #1;
            checks++;
            if ({mem_req, mem_we, mem_addr, mem_wdata, data_ack} !== {1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 1'b0}) begin
                errors++;
                $display("[TB] FAIL store_busy_c%0d got=req%b we%b %h %h ack%b exp=req1 we1 00000100 deadbeef ack0",
                         c, mem_req, mem_we, mem_addr, mem_wdata, data_ack);
            end
        end
        tick(); #1;
        checks++;
        if ({data_ack, mem_req, stall} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL store_ack_c4 got=ack%b req%b stall%b exp=ack1 req0 stall0", data_ack, mem_req, stall);
        end
        checks++;
        if (data_rdata !== 32'h1234_5678) begin errors++; $display("[TB] FAIL store_rdata_kept got=%h exp=12345678", data_rdata); end
        tick();
        data_rd_en = 1'b0;  data_wr_en = 1'b0;
    endtask

    task automatic test_spurious_and_drop();
        int   acks;
        int   rises;
        logic prev_req;
        do_reset();
        mem_auto = 1'b0;
        mem_ack = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick(); #1;
            checks++;
            if ({mem_req, instr_ack, data_ack} !== 3'b000) begin
                errors++;
                $display("[TB] FAIL spurious_c%0d got=req%b iack%b dack%b exp=000", c, mem_req, instr_ack, data_ack);
            end
        end
        mem_auto = 1'b1;
        mem_lat_fixed = 3;
        dev_mem[2] = 32'hCAFE_F00D;
        data_addr = 32'h108;
        data_rd_en = 1'b1;
        acks = 0;  rises = 0;  prev_req = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (c == 2) data_rd_en = 1'b0;
            #1;
            if (mem_req && !prev_req) rises++;
            prev_req = mem_req;
            if (data_ack) acks++;
            if (c == 3) begin
                checks++;
                if ({mem_req, stall} !== 2'b10) begin errors++; $display("[TB] FAIL drop_busy_c3 got=req%b stall%b exp=req1 stall0", mem_req, stall); end
            end
            if (c == 4) begin
                checks++;
                if ({data_ack, data_rdata} !== {1'b1, 32'hCAFE_F00D}) begin
                    errors++;
                    $display("[TB] FAIL drop_ack_c4 got=ack%b %h exp=ack1 cafef00d", data_ack, data_rdata);
                end
            end
        end
        checks++;
        if (acks != 1 || rises != 1) begin errors++; $display("[TB] FAIL drop_counts got=acks%0d grants%0d exp=1 1", acks, rises); end
    endtask

    task automatic test_reset_mid_busy();
        int events;
        do_reset();
        dev_mem[4] = 32'h0BAD_F00D;
        data_addr = 32'h10;
        data_rd_en = 1'b1;
        tick();
        tick();
        tick();
        data_rd_en = 1'b0;
        mem_auto = 1'b0;
        instr_addr = 20'h00020;
        instr_rd_en = 1'b1;
        tick(); #1;
        checks++;
        if ({mem_req, data_rdata} !== {1'b1, 32'h0BAD_F00D}) begin
            errors++;
            $display("[TB] FAIL rstbusy_setup got=req%b %h exp=req1 0badf00d", mem_req, data_rdata);
        end
        tick();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({mem_req, mem_we, instr_ack, data_ack} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL rstbusy_async_ctrl got=%b exp=0000", {mem_req, mem_we, instr_ack, data_ack});
        end
        checks++;
        if (mem_addr !== '0 || data_rdata !== '0 || instr_rdata !== '0) begin
            errors++;
            $display("[TB] FAIL rstbusy_async_regs got=%h %h %h exp=0 0 0", mem_addr, data_rdata, instr_rdata);
        end
        instr_rd_en = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        mem_auto = 1'b1;
        events = 0;
        for (int c = 0; c < 6; c++) begin
            tick(); #1;
            if (mem_req || instr_ack || data_ack) events++;
        end
        checks++;
        if (events != 0) begin errors++; $display("[TB] FAIL rstbusy_no_replay got=%0d events exp=0", events); end
    endtask

    // Randomized traffic against a transaction-level model: the memory is free one
    // cycle after each ack, a pending request is granted on the next edge, the ack
    // comes one cycle after the device answers, and reads return the reference memory.
    task automatic test_random();
        logic           inflight, ack_due, grant_due, own_data;
        logic           g_data, g_we, c_we;
        logic [MAW-1:0] g_addr, c_addr;
        logic [DW-1:0]  g_wdata, c_wdata;
        logic           exp_iack, exp_dack, exp_stall, drop_i, drop_d;
        logic [DW-1:0]  exp_ir, exp_dr;
        int             streak;
        int unsigned    r;
        do_reset();
        mem_lat_rand = 1'b1;
        for (int i = 0; i < 64; i++) begin
            dev_mem[i] = $urandom;
            ref_mem[i] = dev_mem[i];
        end
        inflight = 0;  ack_due = 0;  grant_due = 0;  own_data = 0;  streak = 0;
        g_data = 0;  g_we = 0;  g_addr = '0;  g_wdata = '0;
        c_we = 0;  c_addr = '0;  c_wdata = '0;
        exp_ir = '0;  exp_dr = '0;  drop_i = 0;  drop_d = 0;
        for (int cyc = 0; cyc < 1600; cyc++) begin
            tick();
            if (drop_i) instr_rd_en = 1'b0;
            if (drop_d) begin data_rd_en = 1'b0; data_wr_en = 1'b0; end
            if (cyc < 1500) begin
                if (!instr_rd_en && $urandom_range(0, 1) == 1) begin
                    instr_rd_en = 1'b1;
                    instr_addr = IAW'($urandom);
                end
                if (!data_rd_en && !data_wr_en && $urandom_range(0, 3) != 0) begin
                    r = $urandom_range(0, 2);
                    data_wr_en = (r != 0);
                    data_rd_en = (r != 1);
                    data_addr  = $urandom;
                    data_write = $urandom;
                end
            end
            #1;
            exp_iack = 1'b0;
            exp_dack = 1'b0;
            if (ack_due) begin
                inflight = 1'b0;
                if (own_data) begin
                    exp_dack = 1'b1;
                    if (c_we) ref_mem[c_addr[7:2]] = c_wdata;
                    else      exp_dr = ref_mem[c_addr[7:2]];
                end else begin
                    exp_iack = 1'b1;
                    exp_ir = ref_mem[c_addr[7:2]];
                end
            end
            if (grant_due) begin
                inflight = 1'b1;
                own_data = g_data;  c_addr = g_addr;  c_we = g_we;  c_wdata = g_wdata;
            end
            checks++;
            if (mem_req !== inflight) begin errors++; $display("[TB] FAIL rnd_mem_req cyc=%0d got=%b exp=%b", cyc, mem_req, inflight); end
            if (inflight) begin
                checks++;
                if ({mem_addr, mem_we} !== {c_addr, c_we} || (c_we && mem_wdata !== c_wdata)) begin
                    errors++;
                    $display("[TB] FAIL rnd_mem_bus cyc=%0d got=%h we%b %h exp=%h we%b %h", cyc, mem_addr, mem_we, mem_wdata, c_addr, c_we, c_wdata);
                end
            end
            checks++;
            if ({instr_ack, data_ack} !== {exp_iack, exp_dack}) begin
                errors++;
                $display("[TB] FAIL rnd_acks cyc=%0d got=i%b d%b exp=i%b d%b", cyc, instr_ack, data_ack, exp_iack, exp_dack);
            end
            checks++;
            if (instr_rdata !== exp_ir || data_rdata !== exp_dr) begin
                errors++;
                $display("[TB] FAIL rnd_rdata cyc=%0d got=%h/%h exp=%h/%h", cyc, instr_rdata, data_rdata, exp_ir, exp_dr);
            end
            exp_stall = (instr_rd_en & ~exp_iack) | ((data_rd_en | data_wr_en) & ~exp_dack);
            checks++;
            if (stall !== exp_stall) begin errors++; $display("[TB] FAIL rnd_stall cyc=%0d got=%b exp=%b", cyc, stall, exp_stall); end

            drop_i = exp_iack;
            drop_d = exp_dack;
            ack_due = inflight && mem_ack;
            grant_due = 1'b0;
            if (!inflight && !exp_iack && !exp_dack && (instr_rd_en || data_rd_en || data_wr_en)) begin
                grant_due = 1'b1;
                if (instr_rd_en && (!(data_rd_en || data_wr_en) || streak == BURST)) begin
                    g_data = 1'b0;  g_we = 1'b0;  g_addr = MAW'(instr_addr);  g_wdata = '0;
                    streak = 0;
                end else begin
                    g_data = 1'b1;  g_we = data_wr_en;  g_addr = MAW'(data_addr);  g_wdata = data_write;
                    streak = instr_rd_en ? ((streak < 15) ? streak + 1 : 15) : 0;
                end
            end
        end
        checks++;
        if (instr_rd_en || data_rd_en || data_wr_en || inflight) begin
            errors++;
            $display("[TB] FAIL rnd_drain got=pending exp=all served");
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        $display("[TB] starting dlx_mem_arbiter bench");
        test_reset();
        test_single_fetch();
        test_simultaneous();
        test_starvation();
        test_store();
        test_spurious_and_drop();
        test_reset_mid_busy();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
